// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined IEEE-754 multiplier: round modes, flag indices,
// operand classes and format helpers.
package fp_pkg;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to their width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
    logic [63:0] e_ones;
    e_ones = (64'd1 << exp_w) - 64'd1;
    return (e_ones << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle of the pipelined multiplier.
interface fp_mul_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 5
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic             iValid;
  logic             oReady;
  logic [W-1:0]     iA;
  logic [W-1:0]     iB;
  logic             iRm;
  logic [TAG_W-1:0] iTag;
  logic             oValid;
  logic             iReady;
  logic [W-1:0]     oProd;
  logic [4:0]       oFlags;
  logic [TAG_W-1:0] oTag;

  modport master (
    output iValid, iA, iB, iRm, iTag, iReady,
    input  oReady, oValid, oProd, oFlags, oTag
  );

  modport slave (
    input  iValid, iA, iB, iRm, iTag, iReady,
    output oReady, oValid, oProd, oFlags, oTag
  );

endinterface

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 operand into sign, exponent and significand and classifies it.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [EXP_W+FRAC_W:0] op_i,
  output logic                  sign_o,
  output logic [EXP_W-1:0]      exp_o,
  output logic [FRAC_W:0]       mant_o,
  output fp_class_e             cls_o,
  output logic                  snan_o
);
  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_ones;

  assign sign_o   = op_i[EXP_W+FRAC_W];
  assign exp_o    = op_i[FRAC_W +: EXP_W];
  assign frac     = op_i[FRAC_W-1:0];
  assign exp_zero = (exp_o == '0);
  assign exp_ones = &exp_o;
  assign mant_o   = {!exp_zero, frac};

  // Denormals fall into CLS_ZERO: they are flushed, never multiplied.
  always_comb begin
    cls_o = CLS_NORM;
    if (exp_zero)      cls_o = CLS_ZERO;
    else if (exp_ones) cls_o = (frac == '0) ? CLS_INF : CLS_NAN;
  end

  assign snan_o = exp_ones && (frac != '0) && !frac[FRAC_W-1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier with valid/ready handshake, RNE/RTZ rounding,
// special-value handling and RISC-V style exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 5
) (
  input  logic         iCLK,
  input  logic         iRST,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;
  localparam int XW = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS_S  = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic [W-1:0]         QNAN    = W'(fp_qnan(EXP_W, FRAC_W));

  function automatic logic rne_inc(input logic rm, input logic lsb, input logic g,
                                   input logic s);
    return (rm == RM_RNE) && g && (s || lsb);
  endfunction

  function automatic logic [W-1:0] ovf_result(input logic sign, input logic rm);
    return (rm == RM_RTZ) ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}}
                          : {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

  logic en;
  logic vld_p0_q, vld_p1_q, vld_p2_q;

  assign en         = !vld_p2_q || bus.iReady;
  assign bus.oReady = en;

  // S1: unpack, classify, sign and exponent sum
  logic            sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [FRAC_W:0] mant_a, mant_b;
  fp_class_e       cls_a, cls_b;
  logic            snan_a, snan_b;

  fp_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_a (
    .op_i(bus.iA), .sign_o(sign_a), .exp_o(exp_a), .mant_o(mant_a),
    .cls_o(cls_a), .snan_o(snan_a)
  );

  fp_unpack #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_unpack_b (
    .op_i(bus.iB), .sign_o(sign_b), .exp_o(exp_b), .mant_o(mant_b),
    .cls_o(cls_b), .snan_o(snan_b)
  );

  logic                 sign_p0_d;
  logic signed [XW-1:0] exp_p0_d;
  logic                 special_p0_d;
  logic                 spec_nv_p0_d;
  logic [W-1:0]         spec_val_p0_d;

  always_comb begin
    sign_p0_d     = sign_a ^ sign_b;
    exp_p0_d      = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS_S;
    special_p0_d  = 1'b1;
    spec_nv_p0_d  = 1'b0;
    spec_val_p0_d = {sign_p0_d, {(W-1){1'b0}}};
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      spec_val_p0_d = QNAN;
      spec_nv_p0_d  = snan_a | snan_b;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      spec_val_p0_d = QNAN;
      spec_nv_p0_d  = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      spec_val_p0_d = {sign_p0_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (cls_a != CLS_ZERO && cls_b != CLS_ZERO) begin
      special_p0_d = 1'b0;
    end
  end

  logic                 sign_p0_q, special_p0_q, spec_nv_p0_q, rm_p0_q;
  logic signed [XW-1:0] exp_p0_q;
  logic [MW-1:0]        mant_a_p0_q, mant_b_p0_q;
  logic [W-1:0]         spec_val_p0_q;
  logic [TAG_W-1:0]     tag_p0_q;

  // S2: significand product
  logic                 sign_p1_q, special_p1_q, spec_nv_p1_q, rm_p1_q;
  logic signed [XW-1:0] exp_p1_q;
  logic [PW-1:0]        prod_p1_q;
  logic [W-1:0]         spec_val_p1_q;
  logic [TAG_W-1:0]     tag_p1_q;

  always_ff @(posedge iCLK) begin
    if (en) begin
      sign_p0_q     <= sign_p0_d;
      exp_p0_q      <= exp_p0_d;
      mant_a_p0_q   <= mant_a;
      mant_b_p0_q   <= mant_b;
      special_p0_q  <= special_p0_d;
      spec_nv_p0_q  <= spec_nv_p0_d;
      spec_val_p0_q <= spec_val_p0_d;
      rm_p0_q       <= bus.iRm;
      tag_p0_q      <= bus.iTag;

      sign_p1_q     <= sign_p0_q;
      exp_p1_q      <= exp_p0_q;
      prod_p1_q     <= PW'(mant_a_p0_q) * PW'(mant_b_p0_q);
      special_p1_q  <= special_p0_q;
      spec_nv_p1_q  <= spec_nv_p0_q;
      spec_val_p1_q <= spec_val_p0_q;
      rm_p1_q       <= rm_p0_q;
      tag_p1_q      <= tag_p0_q;
    end
  end

  // S3: normalise, round, range check, pack
  logic                 norm, g, s;
  logic [FRAC_W-1:0]    frac_n;
  logic [FRAC_W:0]      frac_r;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [W-1:0]         prod_p2_d;
  logic [4:0]           flags_p2_d;

  always_comb begin
    norm   = prod_p1_q[PW-1];
    frac_n = norm ? prod_p1_q[PW-2 -: FRAC_W] : prod_p1_q[PW-3 -: FRAC_W];
    g      = norm ? prod_p1_q[FRAC_W] : prod_p1_q[FRAC_W-1];
    s      = norm ? (|prod_p1_q[FRAC_W-1:0]) : (|prod_p1_q[FRAC_W-2:0]);
    exp_n  = exp_p1_q + $signed({{(XW-1){1'b0}}, norm});
    frac_r = {1'b0, frac_n} + (FRAC_W+1)'(rne_inc(rm_p1_q, frac_n[0], g, s));
    exp_r  = exp_n + $signed({{(XW-1){1'b0}}, frac_r[FRAC_W]});

    flags_p2_d         = '0;
    flags_p2_d[FLG_DZ] = 1'b0;
    prod_p2_d          = {sign_p1_q, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
    if (special_p1_q) begin
      prod_p2_d          = spec_val_p1_q;
      flags_p2_d[FLG_NV] = spec_nv_p1_q;
    end else if (exp_r >= EXP_MAX) begin
      prod_p2_d          = ovf_result(sign_p1_q, rm_p1_q);
      flags_p2_d[FLG_OF] = 1'b1;
      flags_p2_d[FLG_NX] = 1'b1;
    end else if (exp_r < EXP_ONE) begin
      prod_p2_d          = {sign_p1_q, {(W-1){1'b0}}};
      flags_p2_d[FLG_UF] = 1'b1;
      flags_p2_d[FLG_NX] = 1'b1;
    end else begin
      flags_p2_d[FLG_NX] = g | s;
    end
  end

  logic [W-1:0]     prod_p2_q;
  logic [4:0]       flags_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      prod_p2_q  <= '0;
      flags_p2_q <= '0;
      tag_p2_q   <= '0;
    end else if (en) begin
      vld_p0_q   <= bus.iValid;
      vld_p1_q   <= vld_p0_q;
      vld_p2_q   <= vld_p1_q;
      prod_p2_q  <= prod_p2_d;
      flags_p2_q <= flags_p2_d;
      tag_p2_q   <= tag_p1_q;
    end
  end

  assign bus.oValid = vld_p2_q;
  assign bus.oProd  = prod_p2_q;
  assign bus.oFlags = flags_p2_q;
  assign bus.oTag   = tag_p2_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed scoreboard bench for fp_mul_pipe in its default single-precision configuration.
module tb_fp_mul_pipe;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int TAG_W  = 5;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic [31:0] p;
    logic [4:0]  f;
  } vec_t;

  typedef struct packed {
    logic [31:0] p;
    logic [4:0]  f;
    logic [4:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   first_acc = 0;
  vec_t vt[14];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

  fp_mul_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.oValid && bus.iReady) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_output: observed tag %0d prod %0h expected no output",
               bus.oTag, bus.oProd);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("tag_t%0d", e.t), 64'(bus.oTag), 64'(e.t));
        check($sformatf("prod_t%0d", e.t), 64'(bus.oProd), 64'(e.p));
        check($sformatf("flags_t%0d", e.t), 64'(bus.oFlags), 64'(e.f));
      end
    end
  end

  task automatic send(input int vi, input logic [4:0] tag, input bit push);
    int   k;
    exp_t e;
    bus.iValid = 1'b1;
    bus.iA     = vt[vi].a;
    bus.iB     = vt[vi].b;
    bus.iRm    = vt[vi].rm;
    bus.iTag   = tag;
    @(negedge clk);
    k = 0;
    while (!bus.oReady && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.oReady) begin
      n_assert++;
      n_fail++;
      $error("FAIL accept_timeout: observed oReady 0 for tag %0d, expected 1", tag);
    end else if (push) begin
      e.p = vt[vi].p;
      e.f = vt[vi].f;
      e.t = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    last_acc   = cyc;
    bus.iValid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};
    vt[1]  = '{32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 5'b00001};
    vt[2]  = '{32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 5'b00001};
    vt[3]  = '{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 5'b00101};
    vt[4]  = '{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F7FFFFF, 5'b00101};
    vt[5]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 5'b10000};
    vt[6]  = '{32'h80800000, 32'h00800000, 1'b0, 32'h80000000, 5'b00011};
    vt[7]  = '{32'h40000000, 32'h40400000, 1'b0, 32'h40C00000, 5'b00000};
    vt[8]  = '{32'h7F800000, 32'hC0000000, 1'b0, 32'hFF800000, 5'b00000};
    vt[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b10000};
    vt[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b00000};
    vt[11] = '{32'h00000000, 32'hC0400000, 1'b0, 32'h80000000, 5'b00000};
    vt[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 5'b00000};
    vt[13] = '{32'hC0A00000, 32'h3E800000, 1'b0, 32'hBFA00000, 5'b00000};

    rst        = 1'b1;
    bus.iValid = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    bus.iRm    = 1'b0;
    bus.iTag   = '0;
    bus.iReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oValid", 64'(bus.oValid), 64'd0);
    check("rst_oProd", 64'(bus.oProd), 64'd0);
    check("rst_oFlags", 64'(bus.oFlags), 64'd0);
    check("rst_oTag", 64'(bus.oTag), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_oReady", 64'(bus.oReady), 64'd1);
    @(posedge clk);
    #1;

    // Latency: oValid appears after the third rising edge counting the accept edge.
    send(0, 5'd0, 1'b1);
    @(negedge clk);
    check("lat_edge1", 64'(bus.oValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge2", 64'(bus.oValid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge3", 64'(bus.oValid), 64'd1);
    drain("drain_latency");

    for (int i = 1; i < 14; i++) send(i, 5'(i), 1'b1);
    drain("drain_directed");

    // Eight back-to-back ops with the consumer stalled for four cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(6 + i, 5'(16 + i), 1'b1);
          if (i == 0) first_acc = last_acc;
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.iReady = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("stall_oReady", 64'(bus.oReady), 64'd0);
          @(posedge clk);
        end
        #1 bus.iReady = 1'b1;
      end
    join
    check("stream_span", 64'(last_acc - first_acc), 64'd11);
    drain("drain_stream");

    // Reset with three ops in flight: none of them may ever appear.
    bus.iReady = 1'b0;
    send(1, 5'd1, 1'b0);
    send(3, 5'd2, 1'b0);
    send(7, 5'd3, 1'b0);
    check("inflight_oValid", 64'(bus.oValid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_oValid", 64'(bus.oValid), 64'd0);
    check("midrst_oProd", 64'(bus.oProd), 64'd0);
    check("midrst_oFlags", 64'(bus.oFlags), 64'd0);
    check("midrst_oTag", 64'(bus.oTag), 64'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bus.iReady = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(bus.oValid), 64'd0);
    end
    @(posedge clk);
    #1;
    send(13, 5'd30, 1'b1);
    drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
